mem_port_arbiter: RTL and testbench

- Shares the single downstream memory port between the core's instruction-fetch requester (ibus) and data requester (dbus).
- Sits between the core's ibus/dbus interfaces and the memory/cache port. Carries one transaction at a time.
- Priority is configurable, with a starvation guard so fetch always makes progress.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between the fetch
// (ibus) and data (dbus) requesters, one transaction at a time. Fixed
// priority with a starvation guard that forces a grant to the other side.
module mem_port_arbiter #(
  parameter int DBUS_PRIORITY = 1,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        mreq_valid,
  output logic [63:0] mreq_addr,
  output logic [2:0]  mreq_size,
  output logic [7:0]  mreq_strobe,
  output logic [63:0] mreq_data,
  input  logic        mresp_done,
  input  logic [63:0] mresp_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
  localparam bit         D_PRIO = (DBUS_PRIORITY != 0);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       prio_req, other_req;
  logic       gnt_prio, gnt_other, gnt_i, gnt_d;
  logic       done, i_done, d_done;

  // A completion in the same cycle as reset is dropped: reset wins.
  assign done = mresp_done & ~reset;

  // Next state, grant decision and starvation counter update
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    gnt_prio   = 1'b0;
    gnt_other  = 1'b0;
    gnt_i      = 1'b0;
    gnt_d      = 1'b0;
    prio_req   = D_PRIO ? dreq_valid : ireq_valid;
    other_req  = D_PRIO ? ireq_valid : dreq_valid;
    case (state)
      IDLE: begin
        // Priority side wins unless the other side has waited LIMIT grants.
        gnt_prio  = prio_req && !(other_req && (starve_cnt == LIMIT));
        gnt_other = other_req && !gnt_prio;
        gnt_d     = D_PRIO ? gnt_prio  : gnt_other;
        gnt_i     = D_PRIO ? gnt_other : gnt_prio;
        if (gnt_prio) begin
          if (!other_req)               starve_nxt = 4'd0;
          else if (starve_cnt >= LIMIT) starve_nxt = LIMIT;
          else                          starve_nxt = starve_cnt + 4'd1;
        end else if (gnt_other) begin
          starve_nxt = 4'd0;
        end
        if (gnt_i)      state_nxt = BUSY_I;
        else if (gnt_d) state_nxt = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and the registered downstream request fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      mreq_addr   <= 64'd0;
      mreq_size   <= 3'd0;
      mreq_strobe <= 8'd0;
      mreq_data   <= 64'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (gnt_i) begin
        mreq_addr   <= ireq_addr;
        mreq_size   <= 3'd2;
        mreq_strobe <= 8'd0;
        mreq_data   <= 64'd0;
      end else if (gnt_d) begin
        mreq_addr   <= dreq_addr;
        mreq_size   <= dreq_size;
        mreq_strobe <= dreq_strobe;
        mreq_data   <= dreq_data;
      end
    end
  end

  assign mreq_valid = (state == BUSY_I) || (state == BUSY_D);

  // Responses are combinational off mresp_done; only the granted side sees them.
  assign i_done        = (state == BUSY_I) && done;
  assign d_done        = (state == BUSY_D) && done;
  assign iresp_addr_ok = i_done;
  assign iresp_data_ok = i_done;
  assign dresp_addr_ok = d_done;
  assign dresp_data_ok = d_done;
  // Fetch word lane is picked by the latched address, held in mreq_addr.
  assign iresp_data    = !i_done     ? 32'd0 :
                         mreq_addr[2] ? mresp_data[63:32] : mresp_data[31:0];
  assign dresp_data    = d_done ? mresp_data : 64'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven single transactions plus hand-written
// contention, reset-abort and abandoned-request sequences. Expected responses
// go into a scoreboard queue when mresp_done is driven and are popped when
// the arbiter pulses data_ok.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic [2:0]  mreq_size;
  logic [7:0]  mreq_strobe;
  logic [63:0] mreq_data;
  logic        mresp_done;
  logic [63:0] mresp_data;

  mem_port_arbiter #(.DBUS_PRIORITY(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_size(mreq_size),
    .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
    .mresp_done(mresp_done), .mresp_data(mresp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic [63:0] mdata;
    logic [63:0] exp_data;
    int          lat;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check responses at the negedge against the scoreboard, then
  // return 1ns after the next posedge where inputs are driven.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (iresp_data_ok || dresp_data_ok) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {62'd0, dresp_data_ok, iresp_data_ok}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_side", {62'd0, dresp_data_ok, iresp_data_ok}, e.is_d ? 64'd2 : 64'd1);
        chk("resp_addr_ok", {62'd0, dresp_addr_ok, iresp_addr_ok}, e.is_d ? 64'd2 : 64'd1);
        chk("resp_data", e.is_d ? dresp_data : {32'd0, iresp_data}, e.data);
      end
    end else begin
      chk("quiet_resp", dresp_data | {32'd0, iresp_data} |
                        {62'd0, iresp_addr_ok, dresp_addr_ok}, 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mreq(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mreq_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
      cycles++;
    end
    if (!ok) chk("mreq_timeout", 64'd0, 64'd1);
  endtask

  // Drives one request from IDLE, checks the downstream fields and latency,
  // completes it after v.lat extra BUSY cycles.
  task automatic run_req(input vec_t v);
    int   c;
    bit   ok;
    exp_t e;
    if (v.is_d) begin
      dreq_valid = 1'b1; dreq_addr = v.addr; dreq_size = v.size;
      dreq_strobe = v.strobe; dreq_data = v.wdata;
    end else begin
      ireq_valid = 1'b1; ireq_addr = v.addr;
    end
    wait_mreq(c, ok);
    if (ok) begin
      chk("latency", 64'(c), 64'd1);
      chk("mreq_addr", mreq_addr, v.addr);
      chk("mreq_size", {61'd0, mreq_size}, v.is_d ? {61'd0, v.size} : 64'd2);
      chk("mreq_strobe", {56'd0, mreq_strobe}, v.is_d ? {56'd0, v.strobe} : 64'd0);
      chk("mreq_data", mreq_data, v.is_d ? v.wdata : 64'd0);
      for (int i = 0; i < v.lat; i++) begin
        tick();
        chk("mreq_hold", {mreq_valid, mreq_addr[62:0]}, {1'b1, v.addr[62:0]});
      end
      mresp_done = 1'b1;
      mresp_data = v.mdata;
      e.is_d = v.is_d;
      e.data = v.exp_data;
      sb.push_back(e);
      tick();
      mresp_done = 1'b0;
      chk("mreq_release", {63'd0, mreq_valid}, 64'd0);
    end
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
  endtask

  initial begin
    int   c;
    bit   ok;
    int   cnt;
    logic exp_side;
    exp_t e;

    vecs[0] = '{1'b0, 64'h0000_0000_8000_0004, 3'd0, 8'h00, 64'h0,
                64'h1111_2222_3333_4444, 64'h1111_2222, 2};
    vecs[1] = '{1'b1, 64'h0000_0000_8000_1000, 3'd3, 8'hFF, 64'hDEAD_BEEF_0000_0001,
                64'h0, 64'h0, 0};
    vecs[2] = '{1'b0, 64'h0000_0000_8000_0000, 3'd0, 8'h00, 64'h0,
                64'hAAAA_BBBB_CCCC_DDDD, 64'hCCCC_DDDD, 1};
    vecs[3] = '{1'b1, 64'h0000_0000_1234_5678, 3'd0, 8'h00, 64'h0,
                64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 3};
    vecs[4] = '{1'b1, 64'h0000_0000_0000_0040, 3'd2, 8'h0F, 64'h55,
                64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000, 0};
    vecs[5] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd0, 8'h00, 64'h0,
                64'h8765_4321_0FED_CBA9, 64'h8765_4321, 1};

    reset = 1'b1;
    ireq_valid = 1'b0; ireq_addr = '0;
    dreq_valid = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    mresp_done = 1'b0; mresp_data = '0;

    // Reset and idle
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_mreq", {63'd0, mreq_valid} | mreq_addr | mreq_data |
                       {53'd0, mreq_size, mreq_strobe}, 64'd0);
    end
    // mresp_done while idle must not produce a response
    mresp_done = 1'b1;
    mresp_data = 64'hCAFE_F00D_CAFE_F00D;
    tick();
    mresp_done = 1'b0;
    chk("idle_done_ignored", {63'd0, mreq_valid}, 64'd0);

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i]);
      tick();
    end

    // Contention: both requesters hold valid; D has priority, limit 4
    ireq_valid = 1'b1; ireq_addr = 64'h1000;
    dreq_valid = 1'b1; dreq_addr = 64'h2000; dreq_size = 3'd3;
    dreq_strobe = 8'h00; dreq_data = 64'h0;
    cnt = 0;
    for (int g = 0; g < 10; g++) begin
      wait_mreq(c, ok);
      if (!ok) break;
      chk("grant_gap", 64'(c), 64'd1);
      if (cnt == 4) begin exp_side = 1'b0; cnt = 0; end
      else          begin exp_side = 1'b1; cnt++;   end
      chk("grant_seq", {63'd0, mreq_addr == 64'h2000}, {63'd0, exp_side});
      tick();
      mresp_done = 1'b1;
      mresp_data = 64'h0000_0001_0000_0000 + 64'(g);
      e.is_d = exp_side;
      e.data = exp_side ? mresp_data : {32'd0, mresp_data[31:0]};
      sb.push_back(e);
      tick();
      mresp_done = 1'b0;
    end
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    tick();

    // Reset while BUSY_D: transaction abandoned, late mresp_done ignored
    dreq_valid = 1'b1; dreq_addr = 64'h3000; dreq_size = 3'd3;
    dreq_strobe = 8'h0F; dreq_data = 64'h1234;
    wait_mreq(c, ok);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dreq_valid = 1'b0;
    chk("rst_mreq_valid", {63'd0, mreq_valid}, 64'd0);
    chk("rst_mreq_addr", mreq_addr, 64'd0);
    mresp_done = 1'b1;
    mresp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mresp_done = 1'b0;
    run_req('{1'b0, 64'h8000_0104, 3'd0, 8'h00, 64'h0,
              64'h5555_6666_7777_8888, 64'h5555_6666, 1});
    tick();

    // Abandoned fetch: valid dropped while BUSY_I, still completes once
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0008;
    wait_mreq(c, ok);
    ireq_valid = 1'b0;
    tick();
    chk("abandon_busy", {63'd0, mreq_valid}, 64'd1);
    mresp_done = 1'b1;
    mresp_data = 64'h9999_AAAA_BBBB_CCCC;
    e.is_d = 1'b0;
    e.data = 64'hBBBB_CCCC;
    sb.push_back(e);
    tick();
    mresp_done = 1'b0;
    chk("abandon_idle", {63'd0, mreq_valid}, 64'd0);
    tick();
    chk("abandon_sb_empty", 64'(sb.size()), 64'd0);
    run_req('{1'b1, 64'h0000_0000_8000_2000, 3'd3, 8'h00, 64'h0,
              64'h0F0F_0F0F_F0F0_F0F0, 64'h0F0F_0F0F_F0F0_F0F0, 1});
    tick();
    tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
